mips_avalon_arbiter: RTL

Two-master to one-slave Avalon-MM arbiter in front of the shared memory slave. Port 0 carries instruction fetches and port 1 carries load/store traffic (a Harvard-style CPU core) into a single mips_avalon_slave. Only one master owns the slave at a time. Ownership is granted round-robin, held until the transfer completes, and monitored for protocol errors and stalls.

---
 rtl/mips_avalon_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mips_avalon_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of a single memory slave.
// Owner signals are forwarded combinationally; protocol and stall monitors are sticky.
module mips_avalon_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIRST_GRANT    = 0
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,

  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,

  output logic [1:0]          grant,
  output logic                protocol_error,
  output logic                stall_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic LAST_RESET = (FIRST_GRANT == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             last, last_next;
  logic             req0, req1;
  logic             owner_req, stalling;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_inc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= LAST_RESET;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Completion hands straight to a waiting peer; the owner itself always re-arbitrates via IDLE.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = last ? GRANT0 : GRANT1;
        else if (req0)
          state_next = GRANT0;
        else if (req1)
          state_next = GRANT1;
      end
      GRANT0: begin
        if (!req0) begin
          state_next = IDLE;
        end else if (!s_waitrequest) begin
          last_next  = 1'b0;
          state_next = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (!s_waitrequest) begin
          last_next  = 1'b1;
          state_next = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_address      = '0;
    s_byteenable   = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    grant          = 2'b00;
    case (state)
      GRANT0: begin
        grant          = 2'b01;
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_read         = m0_read & ~reset;
        s_write        = m0_write & ~reset;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
        m0_readdata    = s_readdata;
      end
      GRANT1: begin
        grant          = 2'b10;
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_read         = m1_read & ~reset;
        s_write        = m1_write & ~reset;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
        m1_readdata    = s_readdata;
      end
      default: ;
    endcase
  end

  assign owner_req     = ((state == GRANT0) && req0) || ((state == GRANT1) && req1);
  assign stalling      = owner_req && s_waitrequest;
  assign stall_cnt_inc = stall_cnt + CNT_W'(1);

  // Counter saturates so the flag only reports; the transfer itself is left to finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else if (!stalling) begin
      stall_cnt <= '0;
    end else if ((TIMEOUT_CYCLES != 0) && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt_inc;
      if (stall_cnt_inc == STALL_MAX)
        stall_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      protocol_error <= 1'b0;
    else if ((m0_read && m0_write) || (m1_read && m1_write))
      protocol_error <= 1'b1;
  end

endmodule
